// File: rtl/byte_word_packer_pkg.sv
// Shared types and helpers for the byte-to-word packer.
//   BYTE_W, WORD_BYTES : datapath geometry (8-bit bytes, 4 bytes per word)
//   keep_t             : 4-bit lane-valid mask, bit 3 = lane [31:24]
//   cnt_t              : byte count / lane index inside a word
//   keep_from_count    : keep mask for a word holding n_minus_1+1 bytes
package byte_pack_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [3:0] keep_t;
  typedef logic [1:0] cnt_t;

  function automatic keep_t keep_from_count(cnt_t n_minus_1);
    keep_t k;
    case (n_minus_1)
      2'd0:    k = 4'b1000;
      2'd1:    k = 4'b1100;
      2'd2:    k = 4'b1110;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out stream bundle for byte_word_packer.
//   s_valid/s_ready/s_data/s_last : upstream byte stream
//   m_valid/m_ready/m_data/m_keep/m_last : downstream word stream
// Modports:
//   slave  - the packer's view (consumes bytes, produces words)
//   master - the environment's view (produces bytes, consumes words)
interface byte_word_packer_if;
  import byte_pack_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  keep_t             m_keep;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/byte_word_packer_out_reg.sv
// pack_out_reg: single-entry output register of the packer.
//   clk, rst_n   : clock, synchronous active-low reset
//   load*        : word to capture (load is only raised when can_load=1)
//   m_ready      : downstream ready
//   m_valid/m_data/m_keep/m_last : registered word outputs
//   can_load     : register is empty or being drained this cycle
module pack_out_reg
  import byte_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  keep_t       load_keep,
  input  logic        load_last,
  input  logic        m_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  output keep_t       m_keep,
  output logic        m_last,
  output logic        can_load
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  keep_t       keep_q, keep_d;
  logic        last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
      last_d  = load_last;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign can_load = !valid_q || m_ready;
  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_keep   = keep_q;
  assign m_last   = last_q;

endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a valid/ready byte stream into big-endian 32-bit
// words (first byte in [31:24]) with a lane-keep mask. A word is emitted when
// four bytes are collected or on s_last; unused lanes hold PAD_BYTE.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : (only with PACKER_FLUSH_EN) emit the partial word, m_last=0
//   bus        : byte_word_packer_if.slave (byte input, word output)
// Parameters: PAD_BYTE (pad value), WORD_BYTES (must be 4).
module byte_word_packer
  import byte_pack_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE   = 8'h00,
  parameter int unsigned WORD_BYTES = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef PACKER_FLUSH_EN
  input logic flush,
`endif
  byte_word_packer_if.slave bus
);

  localparam cnt_t LAST_LANE = cnt_t'(WORD_BYTES - 1);

  cnt_t                   cnt_q, cnt_d;
  logic [3:0][BYTE_W-1:0] coll_q, coll_d;   // index = lane, lane 0 -> [31:24]
  logic [3:0][BYTE_W-1:0] word;             // index 3 -> [31:24]
  logic                   can_load;
  logic                   accept;
  logic                   close_word;
  logic                   flush_partial;
  logic                   load;
  logic                   load_last;
  cnt_t                   fill_m1;
  cnt_t                   lane;

  assign bus.s_ready = rst_n && can_load;
  assign accept      = bus.s_valid && bus.s_ready;

  always_comb begin
    cnt_d         = cnt_q;
    coll_d        = coll_q;
    word          = '0;
    lane          = '0;
    close_word    = accept && ((cnt_q == LAST_LANE) || bus.s_last);
`ifdef PACKER_FLUSH_EN
    // A byte accepted alongside flush is folded into the flushed word.
    flush_partial = flush && bus.s_ready && (accept || (cnt_q != '0)) && !close_word;
`else
    flush_partial = 1'b0;
`endif
    load          = close_word || flush_partial;
    load_last     = close_word && bus.s_last;
    fill_m1       = accept ? cnt_q : cnt_q - cnt_t'(1);

    for (int unsigned i = 0; i < 4; i++) begin
      lane = cnt_t'(i);
      if (lane < cnt_q)
        word[~lane] = coll_q[lane];
      else if (accept && (lane == cnt_q))
        word[~lane] = bus.s_data;
      else
        word[~lane] = PAD_BYTE;
    end

    if (load) begin
      cnt_d  = '0;
      coll_d = '0;
    end else if (accept) begin
      coll_d[cnt_q] = bus.s_data;
      cnt_d         = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      coll_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      coll_q <= coll_d;
    end
  end

  pack_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (word),
    .load_keep (keep_from_count(fill_m1)),
    .load_last (load_last),
    .m_ready   (bus.m_ready),
    .m_valid   (bus.m_valid),
    .m_data    (bus.m_data),
    .m_keep    (bus.m_keep),
    .m_last    (bus.m_last),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: directed byte strings, a
// reference packing model feeding a scoreboard, and a negedge monitor that
// pops and compares every word handshake.
module tb_byte_word_packer;
  import byte_pack_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef PACKER_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  byte_word_packer_if bus ();

  byte_word_packer #(.PAD_BYTE(8'h00), .WORD_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PACKER_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    keep_t       keep;
    logic        last;
  } word_t;

  word_t       sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_word = '0;
  int          m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input logic last);
    word_t w;
    w.data = m_word;
    w.keep = 4'(4'b1111 << (4 - m_cnt));
    w.last = last;
    sb.push_back(w);
    m_word = '0;
    m_cnt  = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic last);
    m_word[31 - 8*m_cnt -: 8] = d;
    m_cnt++;
    if (last || m_cnt == 4) model_push(last);
  endfunction

  // Every negedge with valid && ready is exactly one handshake at the next edge.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      check("word_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        word_t w;
        w = sb.pop_front();
        check("sb_data", bus.m_data, w.data);
        check("sb_keep", 32'(bus.m_keep), 32'(w.keep));
        check("sb_last", 32'(bus.m_last), 32'(w.last));
      end
    end
  end

  // Returns #1 after the edge at which the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int  n;
    logic ok;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    forever begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        model_accept(d, last);
        break;
      end
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  bus.m_data,       32'h0);
    check("rst_m_keep",  32'(bus.m_keep),  32'h0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "ABCD" -> one full word, one cycle after 'D'
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b0);
    check("abcd_not_early", 32'(bus.m_valid), 32'd0);
    send_byte(8'h44, 1'b1);
    idle();
    check("abcd_valid", 32'(bus.m_valid), 32'd1);
    check("abcd_data",  bus.m_data,       32'h41424344);
    check("abcd_keep",  32'(bus.m_keep),  32'hF);
    check("abcd_last",  32'(bus.m_last),  32'd1);
    @(posedge clk); #1;
    check("abcd_no_extra", 32'(bus.m_valid), 32'd0);

    // 01..07 -> full word then padded 3-byte word
    for (int i = 1; i <= 7; i++) begin
      send_byte(8'(i), i == 7);
      if (i == 4) begin
        check("seq7_w0_data", bus.m_data,      32'h01020304);
        check("seq7_w0_keep", 32'(bus.m_keep), 32'hF);
        check("seq7_w0_last", 32'(bus.m_last), 32'd0);
      end
    end
    idle();
    check("seq7_w1_data", bus.m_data,      32'h05060700);
    check("seq7_w1_keep", 32'(bus.m_keep), 32'hE);
    check("seq7_w1_last", 32'(bus.m_last), 32'd1);
    @(posedge clk); #1;

    // single byte string
    send_byte(8'hAA, 1'b1);
    idle();
    check("single_data", bus.m_data,      32'hAA000000);
    check("single_keep", 32'(bus.m_keep), 32'h8);
    check("single_last", 32'(bus.m_last), 32'd1);
    @(posedge clk); #1;

    // back-pressure: word pending with m_ready=0 for 5 cycles, 12 bytes total
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_byte(8'(i * 16), 1'b0);
    check("stall_valid", 32'(bus.m_valid), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h50;
    bus.s_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_ready", 32'(bus.s_ready), 32'd0);
      check("stall_data",    bus.m_data,       32'h10203040);
      check("stall_keep",    32'(bus.m_keep),  32'hF);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int i = 5; i <= 12; i++) send_byte(8'(i * 16), i == 12);
    idle();
    @(posedge clk); #1;

    // reset mid-string discards the partial word
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    idle();
    rst_n  = 1'b0;
    m_word = '0;
    m_cnt  = 0;
    @(negedge clk);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_m_valid", 32'(bus.m_valid), 32'd0);
    send_byte(8'h58, 1'b0);
    send_byte(8'h59, 1'b1);
    idle();
    check("postrst_data", bus.m_data,      32'h58590000);
    check("postrst_keep", 32'(bus.m_keep), 32'hC);
    @(posedge clk); #1;

    // 8-byte string: two full words, no trailing empty word
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), i == 7);
    idle();
    check("len8_last", 32'(bus.m_last), 32'd1);
    @(posedge clk); #1;
    check("len8_no_extra", 32'(bus.m_valid), 32'd0);

`ifdef PACKER_FLUSH_EN
    // flush of a 2-byte partial word, then a fresh word from lane 0
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    if (m_cnt > 0) model_push(1'b0);
    check("flush_valid", 32'(bus.m_valid), 32'd1);
    check("flush_data",  bus.m_data,       32'h11220000);
    check("flush_keep",  32'(bus.m_keep),  32'hC);
    check("flush_last",  32'(bus.m_last),  32'd0);
    send_byte(8'h33, 1'b1);
    idle();
    check("after_flush_data", bus.m_data,      32'h33000000);
    check("after_flush_keep", 32'(bus.m_keep), 32'h8);
    @(posedge clk); #1;
`endif

    // drain and confirm every expected word arrived
    bus.m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end

endmodule
